// File: rtl/vcm_i2c_writer_if.sv
// Bus bundle for vcm_i2c_writer: auto-focus side position word/handshake
// plus the raw I2C pin controls handed to the top-level open-drain pads.
interface vcm_i2c_writer_if;
    logic [15:0] VCM_DATA;     // position word {2'b00, STEP[9:0], 4'b1111}
    logic        FORCE;        // one-cycle resend request
    logic        BUSY;         // frame in progress
    logic        DONE;         // one-cycle end-of-frame pulse
    logic        ACK_ERR;      // sticky NACK flag
    logic        I2C_SCLK;     // 1 = release SCL, 0 = drive low
    logic        I2C_SDAT_OE;  // 1 = drive SDA low, 0 = release
    logic        I2C_SDAT_IN;  // sampled SDA line level

    // The writer is the I2C master.
    modport master (
        input  VCM_DATA, FORCE, I2C_SDAT_IN,
        output BUSY, DONE, ACK_ERR, I2C_SCLK, I2C_SDAT_OE
    );

    // Auto-focus logic plus the pad/slave side.
    modport slave (
        output VCM_DATA, FORCE, I2C_SDAT_IN,
        input  BUSY, DONE, ACK_ERR, I2C_SCLK, I2C_SDAT_OE
    );
endinterface

// File: rtl/vcm_i2c_writer.sv
// VCM position writer: sends {addr+W, hi, lo} to the VCM driver IC whenever
// the position word changes or FORCE is pulsed. Each SCL period is split into
// four quarters of DIV clocks; all bus timing is expressed in quarters.
module vcm_i2c_writer #(
    parameter int         CLK_FREQ   = 50000000,
    parameter int         I2C_FREQ   = 100000,
    parameter logic [6:0] SLAVE_ADDR = 7'h0C
) (
    input  logic            CLK,
    input  logic            RESET,
    vcm_i2c_writer_if.master bus
);

    localparam int DIV = CLK_FREQ / (4 * I2C_FREQ);
    localparam int QW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [QW-1:0] QLAST = QW'(DIV - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_BIT, S_ACK, S_STOP, S_DONE
    } state_t;

    state_t        state, state_nx;
    logic [1:0]    q, q_nx;              // quarter within current slot
    logic [2:0]    bitcnt, bit_nx;       // bit within byte, MSB first
    logic [1:0]    bytecnt, byte_nx;     // 0 = addr+W, 1 = hi, 2 = lo
    logic [QW-1:0] qcnt;
    logic [23:0]   shreg;
    logic [15:0]   last_sent;
    logic          ack_err, frame_nack;

    logic in_frame, qtick, req;
    logic scl, sda_oe, load, shift, nack;

    assign in_frame = (state != S_IDLE) && (state != S_DONE);
    assign qtick    = in_frame && (qcnt == QLAST);
    assign req      = bus.FORCE || (bus.VCM_DATA != last_sent);

    // Quarter timebase: free-runs only inside a frame, so every frame starts
    // with a full-length first quarter.
    always_ff @(posedge CLK) begin
        if (RESET || !in_frame || qtick) qcnt <= '0;
        else                             qcnt <= qcnt + QW'(1);
    end

    // FSM state and slot position registers.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state   <= S_IDLE;
            q       <= 2'd0;
            bitcnt  <= 3'd0;
            bytecnt <= 2'd0;
        end else begin
            state   <= state_nx;
            q       <= q_nx;
            bitcnt  <= bit_nx;
            bytecnt <= byte_nx;
        end
    end

    // Next-state and pin levels per quarter; SDA only moves while SCL is
    // low except for the START and STOP conditions themselves.
    always_comb begin
        state_nx = state;
        q_nx     = q;
        bit_nx   = bitcnt;
        byte_nx  = bytecnt;
        scl      = 1'b1;
        sda_oe   = 1'b0;
        load     = 1'b0;
        shift    = 1'b0;
        nack     = 1'b0;
        case (state)
            S_IDLE: begin
                if (req) begin
                    state_nx = S_START;
                    q_nx     = 2'd0;
                    load     = 1'b1;
                end
            end
            S_START: begin
                sda_oe = (q == 2'd1);
                if (qtick) begin
                    if (q == 2'd1) begin
                        state_nx = S_BIT;
                        q_nx     = 2'd0;
                        bit_nx   = 3'd0;
                        byte_nx  = 2'd0;
                    end else begin
                        q_nx = q + 2'd1;
                    end
                end
            end
            S_BIT: begin
                scl    = (q == 2'd1) || (q == 2'd2);
                sda_oe = ~shreg[23];
                if (qtick) begin
                    if (q == 2'd3) begin
                        q_nx  = 2'd0;
                        shift = 1'b1;
                        if (bitcnt == 3'd7) state_nx = S_ACK;
                        else                bit_nx   = bitcnt + 3'd1;
                    end else begin
                        q_nx = q + 2'd1;
                    end
                end
            end
            S_ACK: begin
                scl = (q == 2'd1) || (q == 2'd2);
                if (qtick) begin
                    if (q == 2'd2 && bus.I2C_SDAT_IN) begin
                        // NACK: abandon the remaining bytes.
                        nack     = 1'b1;
                        state_nx = S_STOP;
                        q_nx     = 2'd0;
                    end else if (q == 2'd3) begin
                        q_nx = 2'd0;
                        if (bytecnt == 2'd2) begin
                            state_nx = S_STOP;
                        end else begin
                            state_nx = S_BIT;
                            bit_nx   = 3'd0;
                            byte_nx  = bytecnt + 2'd1;
                        end
                    end else begin
                        q_nx = q + 2'd1;
                    end
                end
            end
            S_STOP: begin
                scl    = (q != 2'd0);
                sda_oe = (q != 2'd2);
                if (qtick) begin
                    if (q == 2'd2) state_nx = S_DONE;
                    else           q_nx     = q + 2'd1;
                end
            end
            S_DONE: begin
                state_nx = S_IDLE;
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

    // Datapath: frame latch, bit shifter and the sticky NACK flag, which
    // settles to this frame's outcome as the frame ends.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            shreg      <= 24'h0;
            last_sent  <= 16'hFFFF;
            ack_err    <= 1'b0;
            frame_nack <= 1'b0;
        end else begin
            if (load) begin
                shreg      <= {SLAVE_ADDR, 1'b0, bus.VCM_DATA};
                last_sent  <= bus.VCM_DATA;
                frame_nack <= 1'b0;
            end else if (shift) begin
                shreg <= {shreg[22:0], 1'b0};
            end
            if (nack) begin
                ack_err    <= 1'b1;
                frame_nack <= 1'b1;
            end else if (state == S_STOP && state_nx == S_DONE) begin
                ack_err <= frame_nack;
            end
        end
    end

    assign bus.BUSY        = in_frame;
    assign bus.DONE        = (state == S_DONE);
    assign bus.ACK_ERR     = ack_err;
    assign bus.I2C_SCLK    = scl;
    assign bus.I2C_SDAT_OE = sda_oe;

endmodule

// File: tb/tb_vcm_i2c_writer.sv
// Bench for vcm_i2c_writer: DUT A at DIV=1 with a bus decoder and an ACKing
// slave; DUT B at DIV=125 for SCL timing and SDA-change placement.
module tb_vcm_i2c_writer;

    logic CLK, RESET, RESET_B;
    logic slave_nack;
    logic pull_a = 1'b0;
    logic a_sda;
    int   n_chk = 0;
    int   n_err = 0;

    vcm_i2c_writer_if ifa ();
    vcm_i2c_writer_if ifb ();

    vcm_i2c_writer #(.CLK_FREQ(4000000), .I2C_FREQ(1000000), .SLAVE_ADDR(7'h0C))
        dut_a (.CLK(CLK), .RESET(RESET), .bus(ifa));
    vcm_i2c_writer #(.CLK_FREQ(50000000), .I2C_FREQ(100000), .SLAVE_ADDR(7'h0C))
        dut_b (.CLK(CLK), .RESET(RESET_B), .bus(ifb));

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Open-drain SDA line for A: master or slave may pull it low.
    assign a_sda           = ~(ifa.I2C_SDAT_OE | pull_a);
    assign ifa.I2C_SDAT_IN = a_sda;
    // B's slave always ACKs; the master only looks at SDA in the ACK slot.
    assign ifb.I2C_SDAT_IN = 1'b0;

    typedef struct {
        int              nb;
        logic [2:0][7:0] b;
    } frame_t;
    frame_t frames[$];

    // Bus decoder + slave for A.
    logic            prev_scl = 1'b1, prev_sda = 1'b1;
    int              bitn = 0, nb = 0;
    logic [7:0]      sh = 8'h0;
    logic [2:0][7:0] bytes_a = '0;

    always @(negedge CLK) begin
        prev_scl <= ifa.I2C_SCLK;
        prev_sda <= a_sda;
        if (prev_scl && ifa.I2C_SCLK && prev_sda && !a_sda) begin
            bitn <= 0;
            nb   <= 0;
        end else if (prev_scl && ifa.I2C_SCLK && !prev_sda && a_sda) begin
            frames.push_back('{nb, bytes_a});
        end
        if (!prev_scl && ifa.I2C_SCLK) begin
            if (bitn < 8) begin
                sh   <= {sh[6:0], a_sda};
                bitn <= bitn + 1;
            end else begin
                if (nb < 3) bytes_a[nb] <= sh;
                nb   <= nb + 1;
                bitn <= 0;
            end
        end
        if (prev_scl && !ifa.I2C_SCLK) pull_a <= (bitn == 8) && !slave_nack;
    end

    // SCL period and SDA-edge monitor for B.
    int   cyc_b = 0, rise_t = -1, fall_t = -1;
    int   n_high250 = 0, n_high_bad = 0, n_low250 = 0, n_low_other = 0, n_sda_hi = 0;
    logic b_prev_scl = 1'b1, b_prev_oe = 1'b0;

    always @(negedge CLK) begin
        cyc_b      <= cyc_b + 1;
        b_prev_scl <= ifb.I2C_SCLK;
        b_prev_oe  <= ifb.I2C_SDAT_OE;
        if (!b_prev_scl && ifb.I2C_SCLK) begin
            rise_t <= cyc_b;
            if (fall_t >= 0) begin
                if (cyc_b - fall_t == 250) n_low250    <= n_low250 + 1;
                else                       n_low_other <= n_low_other + 1;
            end
        end
        if (b_prev_scl && !ifb.I2C_SCLK) begin
            fall_t <= cyc_b;
            if (rise_t >= 0) begin
                if (cyc_b - rise_t == 250) n_high250  <= n_high250 + 1;
                else                       n_high_bad <= n_high_bad + 1;
            end
        end
        if ((b_prev_oe != ifb.I2C_SDAT_OE) && (b_prev_scl || ifb.I2C_SCLK))
            n_sda_hi <= n_sda_hi + 1;
    end

    task automatic chk1(input string nm, input logic act, input logic exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b want %b", nm, act, exp);
        end
    endtask

    task automatic chk8(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic chkn(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endtask

    // Called at the first negedge where BUSY should be high. Optional poke
    // at clock 'poke_at' of the frame: kind 1 = FORCE pulse, kind 2 = data
    // changes 200F -> 201F -> 202F.
    task automatic measure_frame(input int exp_nb, input logic [7:0] hi,
                                 input logic [7:0] lo, input logic err,
                                 input int exp_len, input int poke_at,
                                 input int kind, input string tg);
        int     len;
        frame_t f;
        chk1({tg, "_busy_rise"}, ifa.BUSY, 1'b1);
        len = 0;
        while (ifa.BUSY === 1'b1 && len < 2000) begin
            len++;
            ifa.FORCE = (kind == 1 && len == poke_at);
            if (kind == 2 && len == poke_at)      ifa.VCM_DATA = 16'h201F;
            if (kind == 2 && len == poke_at + 20) ifa.VCM_DATA = 16'h202F;
            @(negedge CLK);
        end
        ifa.FORCE = 1'b0;
        chkn({tg, "_len"}, len, exp_len);
        chk1({tg, "_done"}, ifa.DONE, 1'b1);
        chk1({tg, "_ack_err"}, ifa.ACK_ERR, err);
        @(negedge CLK);
        chk1({tg, "_done_pulse"}, ifa.DONE, 1'b0);
        chkn({tg, "_frames"}, frames.size(), 1);
        if (frames.size() > 0) begin
            f = frames.pop_front();
            chkn({tg, "_nbytes"}, f.nb, exp_nb);
            chk8({tg, "_addr"}, f.b[0], 8'h18);
            if (exp_nb == 3) begin
                chk8({tg, "_hi"}, f.b[1], hi);
                chk8({tg, "_lo"}, f.b[2], lo);
            end
        end
    endtask

    task automatic check_idle(input string tg);
        int bs;
        bs = 0;
        repeat (20) begin
            if (ifa.BUSY !== 1'b0) bs++;
            @(negedge CLK);
        end
        chkn({tg, "_no_frame"}, bs, 0);
        chkn({tg, "_no_bytes"}, frames.size(), 0);
    endtask

    typedef struct {
        logic [15:0] data;
        logic        frc;
        logic        nack;
        int          nb;
        logic [7:0]  hi;
        logic [7:0]  lo;
        logic        err;
        int          len;
    } vec_t;

    initial begin
        vec_t vt[9];
        int   len;

        vt[0] = '{16'h202F, 1'b1, 1'b0, 3, 8'h20, 8'h2F, 1'b0, 113};
        vt[1] = '{16'h202F, 1'b0, 1'b0, 0, 8'h00, 8'h00, 1'b0, 0};
        vt[2] = '{16'h3FFF, 1'b0, 1'b0, 3, 8'h3F, 8'hFF, 1'b0, 113};
        vt[3] = '{16'h000F, 1'b0, 1'b0, 3, 8'h00, 8'h0F, 1'b0, 113};
        vt[4] = '{16'h155F, 1'b0, 1'b1, 1, 8'h00, 8'h00, 1'b1, 40};
        vt[5] = '{16'h155F, 1'b0, 1'b0, 0, 8'h00, 8'h00, 1'b1, 0};
        vt[6] = '{16'h155F, 1'b1, 1'b0, 3, 8'h15, 8'h5F, 1'b0, 113};
        vt[7] = '{16'h2AAF, 1'b0, 1'b1, 1, 8'h00, 8'h00, 1'b1, 40};
        vt[8] = '{16'h3A5F, 1'b0, 1'b0, 3, 8'h3A, 8'h5F, 1'b0, 113};

        RESET = 1'b1; RESET_B = 1'b1; slave_nack = 1'b0;
        ifa.VCM_DATA = 16'h200F; ifa.FORCE = 1'b0;
        ifb.VCM_DATA = 16'h200F; ifb.FORCE = 1'b0;
        repeat (3) @(negedge CLK);

        chk1("rst_scl",     ifa.I2C_SCLK,    1'b1);
        chk1("rst_oe",      ifa.I2C_SDAT_OE, 1'b0);
        chk1("rst_busy",    ifa.BUSY,        1'b0);
        chk1("rst_done",    ifa.DONE,        1'b0);
        chk1("rst_ack_err", ifa.ACK_ERR,     1'b0);

        // First write is automatic after reset.
        RESET = 1'b0;
        @(negedge CLK);
        measure_frame(3, 8'h20, 8'h0F, 1'b0, 113, 0, 0, "t1");
        check_idle("t1_idle");

        // FORCE resend; a second FORCE mid-frame is dropped.
        ifa.FORCE = 1'b1;
        @(negedge CLK);
        measure_frame(3, 8'h20, 8'h0F, 1'b0, 113, 50, 1, "t2");
        check_idle("t2_idle");

        // Data changes twice mid-frame: only the latest follows.
        ifa.FORCE = 1'b1;
        @(negedge CLK);
        measure_frame(3, 8'h20, 8'h0F, 1'b0, 113, 30, 2, "t3a");
        @(negedge CLK);
        measure_frame(3, 8'h20, 8'h2F, 1'b0, 113, 0, 0, "t3b");
        check_idle("t3_idle");

        for (int i = 0; i < 9; i++) begin
            ifa.VCM_DATA = vt[i].data;
            slave_nack   = vt[i].nack;
            ifa.FORCE    = vt[i].frc;
            @(negedge CLK);
            if (vt[i].nb == 0) begin
                ifa.FORCE = 1'b0;
                check_idle($sformatf("v%0d", i));
                chk1($sformatf("v%0d_ack_err", i), ifa.ACK_ERR, vt[i].err);
            end else begin
                measure_frame(vt[i].nb, vt[i].hi, vt[i].lo, vt[i].err, vt[i].len,
                              0, 0, $sformatf("v%0d", i));
            end
        end

        // Reset mid-frame with ACK_ERR previously set.
        slave_nack = 1'b1;
        ifa.FORCE  = 1'b1;
        @(negedge CLK);
        measure_frame(1, 8'h00, 8'h00, 1'b1, 40, 0, 0, "t5_nack");
        slave_nack = 1'b0;
        ifa.FORCE  = 1'b1;
        @(negedge CLK);
        len = 0;
        while (ifa.BUSY === 1'b1 && len < 40) begin
            len++;
            ifa.FORCE = 1'b0;
            @(negedge CLK);
        end
        chkn("t5_in_frame", len, 40);
        RESET = 1'b1;
        @(negedge CLK);
        chk1("t5_scl",     ifa.I2C_SCLK,    1'b1);
        chk1("t5_oe",      ifa.I2C_SDAT_OE, 1'b0);
        chk1("t5_busy",    ifa.BUSY,        1'b0);
        chk1("t5_done",    ifa.DONE,        1'b0);
        chk1("t5_ack_err", ifa.ACK_ERR,     1'b0);
        RESET = 1'b0;
        @(negedge CLK);
        frames.delete();
        measure_frame(3, 8'h3A, 8'h5F, 1'b0, 113, 0, 0, "t5_restart");
        check_idle("t5_idle");

        // DIV = 125 timing on B.
        RESET_B = 1'b0;
        @(negedge CLK);
        chk1("t6_busy_rise", ifb.BUSY, 1'b1);
        len = 0;
        while (ifb.BUSY === 1'b1 && len < 20000) begin
            len++;
            @(negedge CLK);
        end
        chkn("t6_len", len, 113 * 125);
        chk1("t6_done", ifb.DONE, 1'b1);
        chk1("t6_ack_err", ifb.ACK_ERR, 1'b0);
        @(negedge CLK);
        chkn("t6_high250",  n_high250,   27);
        chkn("t6_high_bad", n_high_bad,  0);
        chkn("t6_low250",   n_low250,    27);
        chkn("t6_low_first", n_low_other, 1);
        chkn("t6_sda_scl_high", n_sda_hi, 2);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/vcm_i2c_writer.md
Name: vcm_i2c_writer

Overview:
Consumes the 16-bit VCM position word {2'b00, STEP[9:0], 4'b1111} produced by the auto-focus controller. Writes it to the VCM driver IC over a single-master I2C bus as START, address+W, high byte, low byte, STOP. A write is launched automatically whenever the word differs from the last value sent, or on an explicit FORCE pulse. Sits between the auto-focus logic and the camera-module I2C pins at top level; the top level does the open-drain tristating.

Parameters:
CLK_FREQ, 50000000, CLK frequency in Hz
I2C_FREQ, 100000, SCL frequency in Hz; DIV = CLK_FREQ/(4*I2C_FREQ), must be >= 1
SLAVE_ADDR, 7'h0C, 7-bit VCM driver address

Ports:
CLK  in  1  system clock, all logic on rising edge
RESET  in  1  synchronous, active-high reset
VCM_DATA  in  16  position word to transmit
FORCE  in  1  one-cycle pulse: resend VCM_DATA even if unchanged
BUSY  out  1  high while a frame is in progress
DONE  out  1  one-cycle pulse at the end of each frame, whether ACKed or not
ACK_ERR  out  1  sticky NACK flag; cleared by the next fully ACKed frame
I2C_SCLK  out  1  1 = release SCL, 0 = drive low
I2C_SDAT_OE  out  1  1 = drive SDA low, 0 = release
I2C_SDAT_IN  in  1  sampled SDA line level

Behaviour:
- Reset values:
  - I2C_SCLK = 1, I2C_SDAT_OE = 0, BUSY = 0, DONE = 0, ACK_ERR = 0.
  - Quarter counter = 0, state = IDLE, last_sent = 16'hFFFF.
  - Because real words have bits [15:14] = 00, the first write happens automatically after reset.
- Tick: a counter generates one-cycle qtick every DIV clocks. The counter runs only while not in IDLE and restarts at 0 on leaving IDLE.
- IDLE:
  - Request = FORCE, or (VCM_DATA != last_sent).
  - On a request: latch shreg = {SLAVE_ADDR, 1'b0, VCM_DATA}, latch last_sent = VCM_DATA, and set BUSY = 1 on the next edge.
  - Latency: request seen in cycle N gives BUSY = 1 in cycle N+1.
- START (2 quarters): q0 SCL=1, SDA released; q1 SDA low. The state ends with SCL driven low.
- BIT state, 8 bits MSB-first per byte, 4 quarters per bit:
  - q0: SCL low, SDA = bit (OE = ~bit).
  - q1 and q2: SCL high.
  - q3: SCL low.
- ACK slot (4 quarters):
  - SDA released, SCL driven as in BIT.
  - I2C_SDAT_IN is sampled on the last clock of q2.
  - 1 = NACK: go to STOP immediately, set ACK_ERR, skip the remaining bytes.
- Byte order: address+W, VCM_DATA[15:8], VCM_DATA[7:0]. Each byte is followed by an ACK slot.
- STOP (3 quarters): q0 SCL low, SDA low; q1 SCL high; q2 SDA released.
- DONE state: one clock with DONE = 1 and BUSY = 0 at the same edge, then IDLE.
  - If all three ACKs were 0, ACK_ERR clears.
- Full ACKed frame = 2 + 27*4 + 3 = 113 quarters = 113*DIV clocks from BUSY rise to DONE.
- VCM_DATA changing mid-frame:
  - The frame in flight is unaffected, since data was latched in IDLE.
  - The new value differs from last_sent, so the next frame starts the cycle after returning to IDLE.
  - Only the latest value is sent; intermediate values may be skipped.
- FORCE during BUSY is ignored (not queued).
- NACK: last_sent still holds the attempted value, so there is no automatic retry. Recovery is by FORCE or by a new value.
- RESET mid-frame: outputs return to their reset values on the next edge. No STOP is generated; the slave resynchronises on the next START.
- Clock stretching and arbitration are not supported. SCL is never read back.

Test Plan:
1. CLK_FREQ=4000000, I2C_FREQ=1000000 (DIV=1), slave model ACKs. Release RESET with VCM_DATA=16'h200F.
   - Required: BUSY 1 cycle after reset release.
   - SDA bytes 0x18, 0x20, 0x0F with START/STOP.
   - DONE pulse 113 clocks after BUSY rise; ACK_ERR=0; no second frame.
2. Hold VCM_DATA constant, pulse FORCE.
   - Required: an identical frame is resent.
   - FORCE pulsed again mid-frame produces no extra frame.
3. Change VCM_DATA 16'h200F -> 16'h201F -> 16'h202F within one frame.
   - Required: exactly one following frame, carrying 0x20, 0x2F.
4. Slave NACKs the address.
   - Required: STOP follows the address ACK slot, no data bytes, ACK_ERR=1, DONE pulses.
   - A following FORCE with ACK clears ACK_ERR.
5. Assert RESET at quarter 40 of a frame.
   - Required: next edge gives I2C_SCLK=1, I2C_SDAT_OE=0, BUSY=0.
   - A new frame starts after release, because last_sent was reset to 16'hFFFF.
6. DIV=125: measure SCL high time.
   - Required: 250 clocks high and 250 low per bit.
   - SDA changes only while SCL is low, except at START and STOP.
